// File: rtl/param_ram_pkg.sv
// param_ram_pkg: shared defaults and parity helper for param_ram.
//   RAM_N_DEF     default address width (depth = 2**N)
//   RAM_M_DEF     default data width
//   RAM_PAR_MAX_W widest word even_parity accepts; narrower words are zero-extended,
//                 and zero-extension does not change the parity.
package param_ram_pkg;

  localparam int unsigned RAM_N_DEF     = 6;
  localparam int unsigned RAM_M_DEF     = 32;
  localparam int unsigned RAM_PAR_MAX_W = 256;

  // Even-parity bit of a word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [RAM_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/param_ram_parity.sv
// param_ram_parity: parity generate/check for param_ram (built only with RAM_PARITY_EN).
//   wdata_i   write data; its parity is stored alongside the word
//   rdata_i   word currently read from the array
//   rpar_i    parity bit stored with rdata_i
//   wpar_c_o  parity bit to store (combinational)
//   err_c_o   stored parity disagrees with the read word (combinational)
`ifdef RAM_PARITY_EN
module param_ram_parity
  import param_ram_pkg::*;
#(
  parameter int unsigned M = RAM_M_DEF
) (
  input  logic [M-1:0] wdata_i,
  input  logic [M-1:0] rdata_i,
  input  logic         rpar_i,
  output logic         wpar_c_o,
  output logic         err_c_o
);

  assign wpar_c_o = even_parity(RAM_PAR_MAX_W'(wdata_i));
  assign err_c_o  = even_parity(RAM_PAR_MAX_W'(rdata_i)) != rpar_i;

endmodule
`endif

// File: rtl/param_ram.sv
// param_ram: single-port RAM, synchronous write, combinational read, synchronous clear.
// Optional feature macro: RAM_PARITY_EN (adds one even-parity bit per word and parity_err).
//   clk        clock; all state changes on the rising edge
//   reset      synchronous active-high; clears every word (wins over we)
//   we         write enable (level-sensitive)
//   adr        shared read/write address
//   din        write data
//   dout       mem[adr], combinational, no write bypass
//   parity_err (RAM_PARITY_EN only) stored parity mismatch for mem[adr]
module param_ram
  import param_ram_pkg::*;
#(
  parameter int unsigned N = RAM_N_DEF,
  parameter int unsigned M = RAM_M_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [N-1:0] adr,
  input  logic [M-1:0] din,
  output logic [M-1:0] dout
`ifdef RAM_PARITY_EN
  ,
  output logic         parity_err
`endif
);

  localparam int unsigned DEPTH = 2 ** N;

  logic [M-1:0] mem_q [DEPTH];

`ifdef RAM_PARITY_EN
  logic par_q [DEPTH];
  logic wpar;

  param_ram_parity #(.M(M)) u_parity (
    .wdata_i  (din),
    .rdata_i  (mem_q[adr]),
    .rpar_i   (par_q[adr]),
    .wpar_c_o (wpar),
    .err_c_o  (parity_err)
  );
`endif

  // Storage: full clear on reset, otherwise write the addressed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[N'(i)] <= '0;
`ifdef RAM_PARITY_EN
        par_q[N'(i)] <= 1'b0;
`endif
      end
    end else if (we) begin
      mem_q[adr] <= din;
`ifdef RAM_PARITY_EN
      par_q[adr] <= wpar;
`endif
    end
  end

  // Read path: old word until the edge, new word after it.
  assign dout = mem_q[adr];

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed and randomized checks of param_ram against an array model.
module tb_param_ram;

  localparam int unsigned N     = 6;
  localparam int unsigned M     = 32;
  localparam int unsigned DEPTH = 2 ** N;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [N-1:0] adr;
  logic [M-1:0] din;
  logic [M-1:0] dout;
`ifdef RAM_PARITY_EN
  logic         parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: a plain word array updated from the driven inputs at each edge.
  logic [M-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  param_ram #(.N(N), .M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .adr   (adr),
    .din   (din),
    .dout  (dout)
`ifdef RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One rising edge; the model applies reset/write with the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    end else if (we) begin
      ref_mem[adr] = din;
    end
    #1;
  endtask

  // Settle combinational read, then compare dout (and parity_err) with the model.
  task automatic check_read(input string tag);
    #1;
    check(tag, dout, ref_mem[adr]);
`ifdef RAM_PARITY_EN
    check({tag, "_par"}, M'(parity_err), '0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    adr   = '0;
    din   = '0;
    tick();
    reset = 1'b0;

    // Whole array reads zero after reset.
    for (int a = 0; a < int'(DEPTH); a++) begin
      adr = N'(a);
      #1;
      check("rst_sweep", dout, '0);
    end

    // First write, then read back.
    we = 1'b1; adr = N'(0); din = 32'h19229210;
    tick();
    we = 1'b0;
    #1;
    check("wr_adr0", dout, 32'h19229210);

    // Second address: no write while we=0, then write.
    adr = N'(1); din = 32'h11922952;
    tick();
    check("adr1_nowe", dout, '0);
    we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    check("adr1_wr", dout, 32'h11922952);
    adr = N'(0);
    #1;
    check("adr0_keep", dout, 32'h19229210);

    // Async read: address changes between edges show up immediately.
    adr = N'(1);
    #1;
    check("async_a1", dout, 32'h11922952);
    adr = N'(0);
    #1;
    check("async_a0", dout, 32'h19229210);
    adr = N'(2);
    #1;
    check("async_a2", dout, '0);

    // Write during reset is dropped.
    we = 1'b1; adr = N'(5); din = 32'hDEADBEEF; reset = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    check("rst_prio", dout, '0);
    adr = N'(0);
    #1;
    check("rst_clr0", dout, '0);

    // Boundary addresses do not alias.
    we = 1'b1; adr = N'(DEPTH - 1); din = 32'hA5A5A5A5;
    tick();
    adr = N'(0); din = 32'h5A5A5A5A;
    tick();
    we = 1'b0;
    adr = N'(DEPTH - 1);
    check_read("bnd_top");
    check("bnd_top_k", dout, 32'hA5A5A5A5);
    adr = N'(0);
    check_read("bnd_bot");
    check("bnd_bot_k", dout, 32'h5A5A5A5A);

    // Randomized traffic: no bypass before the edge, new word after, occasional reset.
    for (int it = 0; it < 400; it++) begin
      reset = ($urandom_range(0, 39) == 0);
      we    = 1'(($urandom_range(0, 2)) != 0);
      adr   = N'($urandom_range(0, DEPTH - 1));
      din   = $urandom;
      check_read("rnd_pre");
      tick();
      check_read("rnd_post");
      reset = 1'b0;
      we    = 1'b0;
      adr   = N'($urandom_range(0, DEPTH - 1));
      check_read("rnd_async");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
